// File: rtl/motor_servo_pwm.sv
// rtl/motor_servo_pwm.sv - H-bridge PWM with reversal dead time, plus 50 Hz servo pulse generator.
// Motor and servo settings are sampled only at period/frame boundaries; every output is registered.
module motor_servo_pwm #(
   parameter int MOTOR_PRESCALE   = 8,
   parameter int DEADTIME_PERIODS = 4,
   parameter int SERVO_PERIOD_CYC = 1000000,
   parameter int SERVO_MIN_CYC    = 50000,
   parameter int SERVO_STEP_CYC   = 277,
   parameter int SERVO_MAX_POS    = 180
) (
   input  logic       input_clk,
   input  logic       input_rst,
   input  logic [7:0] input_motor_duty,
   input  logic       input_motor_dir,
   input  logic [7:0] input_servo_pos,
   output logic       output_motor_in_a,
   output logic       output_motor_in_b,
   output logic       output_motor_dead,
   output logic       output_servo_pulse,
   output logic       output_servo_frame
);

   localparam int PW = (MOTOR_PRESCALE > 1) ? $clog2(MOTOR_PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST     = PW'(MOTOR_PRESCALE - 1);
   localparam logic [PW-1:0] PRE_ONE      = PW'(1);
   localparam logic [3:0]    DEAD_LOAD    = 4'(DEADTIME_PERIODS - 1);
   localparam logic [19:0]   FRAME_LAST   = 20'(SERVO_PERIOD_CYC - 1);
   localparam logic [19:0]   WIDTH_MIN    = 20'(SERVO_MIN_CYC);
   localparam logic [19:0]   WIDTH_STEP   = 20'(SERVO_STEP_CYC);
   localparam logic [19:0]   WIDTH_CENTER = 20'(SERVO_MIN_CYC + 90 * SERVO_STEP_CYC);
   localparam logic [7:0]    MAX_POS      = 8'(SERVO_MAX_POS);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [7:0]  duty_q, duty_d;
   logic        act_dir_q, act_dir_d;
   logic [3:0]  dead_cnt_q, dead_cnt_d;
   logic [19:0] frame_cnt_q, frame_cnt_d;
   logic [19:0] width_q, width_d;
   logic        in_a_q, in_a_d;
   logic        in_b_q, in_b_d;
   logic        dead_q, dead_d;
   logic        pulse_q, pulse_d;
   logic        frame_q, frame_d;

   logic        tick;
   logic        boundary;
   logic        pwm_lvl;
   logic        frame_last;
   logic [7:0]  pos_clamped;
   logic [19:0] new_width;

   always_comb begin
      tick     = (pre_q == PRE_LAST);
      boundary = tick && (pwm_cnt_q == 8'hFF);
      pwm_lvl  = (pwm_cnt_q < duty_q);

      pre_d     = tick ? '0 : pre_q + PRE_ONE;
      pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      duty_d    = boundary ? input_motor_duty : duty_q;

      state_d    = state_q;
      act_dir_d  = act_dir_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (boundary && (input_motor_dir != act_dir_q)) begin
               state_d    = ST_DEAD;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         ST_DEAD: begin
            // Dead time always completes; direction is re-sampled only on exit.
            if (boundary) begin
               if (dead_cnt_q != 4'd0) begin
                  dead_cnt_d = dead_cnt_q - 4'd1;
               end else begin
                  act_dir_d = input_motor_dir;
                  state_d   = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase

      in_a_d = (state_q == ST_RUN) && !act_dir_q && pwm_lvl;
      in_b_d = (state_q == ST_RUN) &&  act_dir_q && pwm_lvl;
      dead_d = (state_q == ST_DEAD);

      pos_clamped = (input_servo_pos > MAX_POS) ? MAX_POS : input_servo_pos;
      new_width   = WIDTH_MIN + ({12'd0, pos_clamped} * WIDTH_STEP);
      frame_last  = (frame_cnt_q == FRAME_LAST);
      frame_cnt_d = frame_last ? 20'd0 : frame_cnt_q + 20'd1;
      width_d     = frame_last ? new_width : width_q;
      pulse_d     = (frame_cnt_q < width_q);
      frame_d     = (frame_cnt_q == 20'd0);
   end

   always_ff @(posedge input_clk) begin
      if (input_rst) begin
         state_q     <= ST_RUN;
         pre_q       <= '0;
         pwm_cnt_q   <= 8'd0;
         duty_q      <= 8'd0;
         act_dir_q   <= 1'b0;
         dead_cnt_q  <= 4'd0;
         frame_cnt_q <= 20'd0;
         width_q     <= WIDTH_CENTER;
         in_a_q      <= 1'b0;
         in_b_q      <= 1'b0;
         dead_q      <= 1'b0;
         pulse_q     <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         pwm_cnt_q   <= pwm_cnt_d;
         duty_q      <= duty_d;
         act_dir_q   <= act_dir_d;
         dead_cnt_q  <= dead_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         width_q     <= width_d;
         in_a_q      <= in_a_d;
         in_b_q      <= in_b_d;
         dead_q      <= dead_d;
         pulse_q     <= pulse_d;
         frame_q     <= frame_d;
      end
   end

   assign output_motor_in_a  = in_a_q;
   assign output_motor_in_b  = in_b_q;
   assign output_motor_dead  = dead_q;
   assign output_servo_pulse = pulse_q;
   assign output_servo_frame = frame_q;

endmodule

// File: tb/tb_motor_servo_pwm.sv
// tb/tb_motor_servo_pwm.sv - randomized and directed bench for motor_servo_pwm against a period-level model.
module tb_motor_servo_pwm;

   localparam int PRE   = 2;
   localparam int DT    = 3;
   localparam int SP    = 3000;
   localparam int SMIN  = 800;
   localparam int SSTEP = 10;
   localparam int SMAX  = 180;
   localparam int PER   = 256 * PRE;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] duty = 8'd0;
   logic       dir = 1'b0;
   logic [7:0] pos = 8'd0;
   logic       in_a, in_b, dead, pulse, frame;

   always #5 clk = ~clk;

   motor_servo_pwm #(
      .MOTOR_PRESCALE(PRE), .DEADTIME_PERIODS(DT), .SERVO_PERIOD_CYC(SP),
      .SERVO_MIN_CYC(SMIN), .SERVO_STEP_CYC(SSTEP), .SERVO_MAX_POS(SMAX)
   ) dut (
      .input_clk(clk), .input_rst(rst),
      .input_motor_duty(duty), .input_motor_dir(dir), .input_servo_pos(pos),
      .output_motor_in_a(in_a), .output_motor_in_b(in_b), .output_motor_dead(dead),
      .output_servo_pulse(pulse), .output_servo_frame(frame)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time index since reset, per-period duty/direction decisions, per-frame width.
   int m_t = 0;
   int m_duty = 0;
   bit m_run = 1'b1;
   bit m_act = 1'b0;
   int m_dead_left = 0;
   int m_width = SMIN + 90 * SSTEP;
   bit m_armed = 1'b0;
   bit e_a = 1'b0, e_b = 1'b0, e_dead = 1'b0, e_pulse = 1'b0, e_frame = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_armed <= 1'b1;
         m_t <= 0;
         m_duty <= 0;
         m_run <= 1'b1;
         m_act <= 1'b0;
         m_dead_left <= 0;
         m_width <= SMIN + 90 * SSTEP;
         e_a <= 1'b0; e_b <= 1'b0; e_dead <= 1'b0; e_pulse <= 1'b0; e_frame <= 1'b0;
      end else begin
         e_a     <= m_run && !m_act && (((m_t % PER) / PRE) < m_duty);
         e_b     <= m_run &&  m_act && (((m_t % PER) / PRE) < m_duty);
         e_dead  <= !m_run;
         e_frame <= ((m_t % SP) == 0);
         e_pulse <= ((m_t % SP) < m_width);
         if ((m_t % PER) == PER - 1) begin
            m_duty <= int'(duty);
            if (m_run) begin
               if (dir != m_act) begin
                  m_run <= 1'b0;
                  m_dead_left <= DT;
               end
            end else if (m_dead_left == 1) begin
               m_run <= 1'b1;
               m_act <= dir;
               m_dead_left <= 0;
            end else begin
               m_dead_left <= m_dead_left - 1;
            end
         end
         if ((m_t % SP) == SP - 1)
            m_width <= SMIN + ((int'(pos) > SMAX) ? SMAX : int'(pos)) * SSTEP;
         m_t <= m_t + 1;
      end
   end

   int cnt_a = 0, cnt_b = 0, cnt_dead = 0, cnt_pulse = 0, cnt_frame = 0;

   always @(negedge clk) begin
      if (m_armed) begin
         chk("in_a", int'(in_a), int'(e_a));
         chk("in_b", int'(in_b), int'(e_b));
         chk("dead", int'(dead), int'(e_dead));
         chk("servo_pulse", int'(pulse), int'(e_pulse));
         chk("servo_frame", int'(frame), int'(e_frame));
         chk("bridge_overlap", int'(in_a & in_b), 0);
         cnt_a     = cnt_a + int'(in_a);
         cnt_b     = cnt_b + int'(in_b);
         cnt_dead  = cnt_dead + int'(dead);
         cnt_pulse = cnt_pulse + int'(pulse);
         cnt_frame = cnt_frame + int'(frame);
      end
   end

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      cnt_a = 0; cnt_b = 0; cnt_dead = 0; cnt_pulse = 0; cnt_frame = 0;
   endtask

   int servo_pos_tab[3] = '{0, 180, 255};
   int servo_exp_tab[3] = '{800, 2600, 2600};

   initial begin
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      clr();
      run(SP);
      chk("first_frame_center_width", cnt_pulse, 1700);
      chk("first_frame_strobes", cnt_frame, 1);
      chk("bridge_off_after_reset", cnt_a + cnt_b + cnt_dead, 0);

      duty = 8'd128;
      run(2 * PER); clr(); run(2 * PER);
      chk("duty128_in_a_high", cnt_a, 512);
      chk("duty128_in_b_high", cnt_b, 0);

      duty = 8'd255;
      run(2 * PER); clr(); run(2 * PER);
      chk("duty255_in_a_high", cnt_a, 1020);

      duty = 8'd200;
      run(2 * PER); clr();
      dir = 1'b1;
      run(5 * PER);
      chk("reversal_dead_cycles", cnt_dead, DT * PER);
      clr(); run(2 * PER);
      chk("reverse_in_b_high", cnt_b, 800);
      chk("reverse_in_a_high", cnt_a, 0);

      clr();
      dir = 1'b0;
      run(PER + 50);
      dir = 1'b1;
      run(5 * PER);
      chk("toggle_dead_cycles", cnt_dead, DT * PER);
      chk("toggle_in_a_high", cnt_a, 0);
      clr(); run(2 * PER);
      chk("toggle_resume_in_b", cnt_b, 800);

      dir = 1'b0;
      run(PER + 100);
      chk("mid_dead_flag", int'(dead), 1);
      rst = 1'b1;
      run(1);
      chk("reset_outputs_low", int'({in_a, in_b, dead, pulse, frame}), 0);
      run(1);
      rst = 1'b0;
      clr(); run(PER);
      chk("post_reset_bridge_off", cnt_a + cnt_b + cnt_dead, 0);
      run(PER); clr(); run(2 * PER);
      chk("post_reset_forward", cnt_a, 800);

      for (int i = 0; i < 3; i++) begin
         pos = 8'(servo_pos_tab[i]);
         run(2 * SP); clr(); run(SP);
         chk("servo_width", cnt_pulse, servo_exp_tab[i]);
         chk("servo_strobe_per_frame", cnt_frame, 1);
      end

      repeat (40) begin
         duty = 8'($urandom);
         dir  = 1'($urandom_range(0, 1));
         pos  = 8'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            run($urandom_range(1, 3));
            rst = 1'b0;
         end
         run($urandom_range(1, 800));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motor_servo_pwm.md
# motor_servo_pwm

Output stage that converts the motor duty/direction and servo position values from the Bluetooth command decoder into physical drive signals. It sits directly downstream of the command decoder and drives the pins to the external H-bridge and hobby servo. It produces:
- two-pin H-bridge PWM with a guaranteed dead interval on every direction reversal;
- a 50 Hz servo pulse of 1–2 ms.

All new values are taken only at period/frame boundaries, so the outputs never glitch.

## Interface
- MOTOR_PRESCALE, 8 — clocks per motor PWM tick; motor period = 256 × MOTOR_PRESCALE clocks.
- DEADTIME_PERIODS, 4 — full motor PWM periods with both bridge inputs low on reversal; legal range 1..15.
- SERVO_PERIOD_CYC, 1000000 — servo frame length in clocks (20 ms at 50 MHz).
- SERVO_MIN_CYC, 50000 — pulse width for position 0 (1 ms).
- SERVO_STEP_CYC, 277 — added pulse clocks per position LSB.
- SERVO_MAX_POS, 180 — position clamp.

Ports:
- input_clk  in  1  system clock, all logic on the rising edge.
- input_rst  in  1  synchronous, active-high reset.
- input_motor_duty  in  8  motor duty, 0..255.
- input_motor_dir  in  1  0 = forward, 1 = reverse.
- input_servo_pos  in  8  servo position, 0..255; values above SERVO_MAX_POS are clamped.
- output_motor_in_a  out  1  forward bridge input (PWM when applied direction = 0).
- output_motor_in_b  out  1  reverse bridge input (PWM when applied direction = 1).
- output_motor_dead  out  1  high while in the DEAD state.
- output_servo_pulse  out  1  servo control pulse.
- output_servo_frame  out  1  one-cycle strobe on the first cycle of each servo frame.

## Operation
- **Motor timebase**
  - Prescaler `pre` counts 0..MOTOR_PRESCALE-1.
  - 8-bit `pwm_cnt` increments (wrapping 255→0) on the cycle where `pre` = MOTOR_PRESCALE-1.
  - Boundary = `pre` = MOTOR_PRESCALE-1 and `pwm_cnt` = 255.
- **Duty latch**
  - `duty_q` loads input_motor_duty only on a boundary.
  - PWM level = (`pwm_cnt` < `duty_q`).
  - duty 0 → constant low; duty 255 → high for 255 of 256 ticks.
- **Direction FSM**: states RUN and DEAD, with an applied-direction register `act_dir`.
  - RUN: drive the PWM level on in_a if `act_dir` = 0, or on in_b if `act_dir` = 1; the other pin is 0.
    - On a boundary where input_motor_dir ≠ `act_dir`: go to DEAD and load `dead_cnt` = DEADTIME_PERIODS-1.
  - DEAD: in_a = in_b = 0; output_motor_dead = 1.
    - Each boundary with `dead_cnt` ≠ 0 decrements it.
    - The boundary with `dead_cnt` = 0 loads `act_dir` from input_motor_dir (re-sampled) and goes to RUN.
    - Dead time always runs to completion, even if input_motor_dir returns to `act_dir` meanwhile. In that case RUN resumes in the original direction.
  - in_a and in_b are never high in the same cycle, in any state.
- **Servo frame**
  - `frame_cnt` counts 0..SERVO_PERIOD_CYC-1 and wraps.
  - output_servo_frame = 1 when `frame_cnt` = 0.
  - On `frame_cnt` = SERVO_PERIOD_CYC-1, `width_q` is loaded with SERVO_MIN_CYC + min(input_servo_pos, SERVO_MAX_POS) × SERVO_STEP_CYC.
  - output_servo_pulse = (`frame_cnt` < `width_q`).
  - Width arithmetic uses 20-bit unsigned values with no overflow at defaults (max 99860).
- **Reset**: all outputs are 0 during reset and in the cycle after it. Internal reset values:
  - `pre` = 0, `pwm_cnt` = 0, `duty_q` = 0;
  - FSM = RUN with `act_dir` = 0, `dead_cnt` = 0;
  - `frame_cnt` = 0, `width_q` = SERVO_MIN_CYC + 90 × SERVO_STEP_CYC (center position).
- **Reset mid-operation**: an in-progress dead interval is abandoned; the block restarts in RUN forward with duty 0, so the bridge stays off until the next boundary.

## Timing
- All outputs are registered.
- Motor:
  - Duty or direction latency is 1 to 256 × MOTOR_PRESCALE clocks (2048 at defaults); a new value is effective from the first cycle of the next period.
  - Reversal: RUN drive stops at the boundary; both pins are low for exactly DEADTIME_PERIODS × 256 × MOTOR_PRESCALE clocks; then the new direction is driven.
- Servo:
  - New position is effective from the next frame start; latency 1 to SERVO_PERIOD_CYC clocks.
  - The pulse rises on the output_servo_frame cycle. The first frame after reset has a center-width pulse.
- Simultaneous duty and direction change at one boundary: `duty_q` updates, but the FSM enters DEAD, so the new duty first appears when RUN resumes.

## Test plan
- Reset released with duty 0 → in_a = in_b = 0 for the first 2048 cycles; servo pulse high for 74930 clocks from the first frame strobe.
- duty = 128, dir = 0 → in_a high 1024 of every 2048 clocks, in_b constantly 0; duty = 255 → in_a high 2040 of 2048.
- dir 0→1 at duty 200 → after the next boundary, both pins low for 8192 clocks with output_motor_dead = 1, then in_b PWMs at 1600/2048; no cycle ever has in_a = in_b = 1.
- dir toggles 0→1→0 within the dead interval → the full 8192-clock dead time completes, then in_a resumes.
- servo_pos 0, 180, 255 → pulse widths 50000, 99860, 99860 clocks in the following frame; frame strobe every 1000000 clocks.
- Reset asserted mid-DEAD → all outputs 0 the next cycle; after release, RUN forward, `duty_q` = 0, and the servo frame restarts at the center width.
